// File: rtl/sop_accumulator_if.sv
// Product stream in, sum stream out, for the sum-of-products accumulator stage.
interface sop_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   sum_valid;
  logic                   sum_ready;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   ovf;

  modport master (
    output in_valid, product, sum_ready,
    input  in_ready, sum_valid, sum, ovf
  );

  modport slave (
    input  in_valid, product, sum_ready,
    output in_ready, sum_valid, sum, ovf
  );
endinterface

// File: rtl/sop_accumulator.sv
// Sums groups of TERMS products into a registered result; optional saturation via SOP_SAT_EN.
// Latency: sum_valid rises one clk after the last term is accepted.
// Backpressure: only the group-completing term stalls while an untaken result is held.
module sop_accumulator #(
  parameter int WIDTH     = 4,
  parameter int TERMS     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+2
) (
  input  logic             clk,
  input  logic             rst_n,
  sop_accumulator_if.slave bus
);
  localparam int            CW   = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERMS-1);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum_q;
  logic [ACC_WIDTH-1:0] add_res;
  logic [CW-1:0]        cnt;
  logic                 sum_valid_q;
  logic                 last;
  logic                 accept;
  logic                 take;

  assign last         = (cnt == LAST);
  assign bus.in_ready = !rst_n || !(last && sum_valid_q && !bus.sum_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign take         = sum_valid_q && bus.sum_ready;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum       = sum_q;

`ifdef SOP_SAT_EN
  logic [ACC_WIDTH:0] add_full;
  logic               acc_ovf;
  logic               add_ovf;
  logic               ovf_q;

  assign add_full = {1'b0, acc} + {1'b0, ACC_WIDTH'(bus.product)};
  assign add_res  = add_full[ACC_WIDTH] ? '1 : add_full[ACC_WIDTH-1:0];
  // Once any add in the group clipped, the group result is flagged.
  assign add_ovf  = acc_ovf | add_full[ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_ovf <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      if (last) begin
        ovf_q   <= add_ovf;
        acc_ovf <= 1'b0;
      end else begin
        acc_ovf <= add_ovf;
      end
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign add_res = acc + ACC_WIDTH'(bus.product);
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= add_res;
          cnt <= cnt + CW'(1);
        end
      end
      // A completing term overrides a take so back-to-back results never drop valid.
      if (accept && last) begin
        sum_q       <= add_res;
        sum_valid_q <= 1'b1;
      end else if (take) begin
        sum_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sop_accumulator.sv
// Three accumulator instances (default, TERMS=1, ACC_WIDTH=9) against a group-sum scoreboard model.
module tb_sop_accumulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] iv;
  logic [2:0] sr;
  logic [7:0] prod [3];
  logic [2:0] ir;
  logic [2:0] sv;
  logic [2:0] ov;
  logic [9:0] sm [3];

  int compared   = 0;
  int mismatched = 0;
  bit started    = 1'b0;

`ifdef SOP_SAT_EN
  localparam int T5_SUM = 511;
  localparam int T5_OVF = 1;
`else
  localparam int T5_SUM = 388;
  localparam int T5_OVF = 0;
`endif

  sop_accumulator_if #(.WIDTH(4), .ACC_WIDTH(10)) if0 ();
  sop_accumulator_if #(.WIDTH(4), .ACC_WIDTH(10)) if1 ();
  sop_accumulator_if #(.WIDTH(4), .ACC_WIDTH(9))  if2 ();

  sop_accumulator #(.WIDTH(4), .TERMS(4), .ACC_WIDTH(10)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sop_accumulator #(.WIDTH(4), .TERMS(1), .ACC_WIDTH(10)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sop_accumulator #(.WIDTH(4), .TERMS(4), .ACC_WIDTH(9))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.in_valid = iv[0];  assign if0.product = prod[0];  assign if0.sum_ready = sr[0];
  assign if1.in_valid = iv[1];  assign if1.product = prod[1];  assign if1.sum_ready = sr[1];
  assign if2.in_valid = iv[2];  assign if2.product = prod[2];  assign if2.sum_ready = sr[2];
  assign ir[0] = if0.in_ready;  assign sv[0] = if0.sum_valid;  assign sm[0] = if0.sum;  assign ov[0] = if0.ovf;
  assign ir[1] = if1.in_ready;  assign sv[1] = if1.sum_valid;  assign sm[1] = if1.sum;  assign ov[1] = if1.ovf;
  assign ir[2] = if2.in_ready;  assign sv[2] = if2.sum_valid;  assign sm[2] = {1'b0, if2.sum};  assign ov[2] = if2.ovf;

  function automatic int terms_of(int i);
    return (i == 1) ? 1 : 4;
  endfunction

  function automatic int aw_of(int i);
    return (i == 2) ? 9 : 10;
  endfunction

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: products accepted so far in the group, their exact sum, and the held result.
  int     cnt_m  [3];
  longint part_m [3];
  bit     rv_m   [3];
  int     rs_m   [3];
  bit     ro_m   [3];
  int     log0[$];
  int     log1[$];
  int     log2[$];

  initial begin
    for (int i = 0; i < 3; i++) begin
      cnt_m[i] = 0; part_m[i] = 0; rv_m[i] = 0; rs_m[i] = 0; ro_m[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        int     t;
        int     exp_rdy;
        int     v;
        bit     acc_ok;
        bit     take;
        longint maxv;
        t    = terms_of(i);
        maxv = (64'd1 << aw_of(i)) - 1;
        exp_rdy = (!rst_n) ? 1 : ((cnt_m[i] == t-1 && rv_m[i] && !sr[i]) ? 0 : 1);
        chk($sformatf("in_ready[%0d]", i), int'(ir[i]), exp_rdy);
        chk($sformatf("sum_valid[%0d]", i), int'(sv[i]), int'(rv_m[i]));
        chk($sformatf("sum[%0d]", i), int'(sm[i]), rs_m[i]);
        chk($sformatf("ovf[%0d]", i), int'(ov[i]), int'(ro_m[i]));
        if (sv[i] && sr[i]) begin
          v = (int'(ov[i]) << 16) | int'(sm[i]);
          if (i == 0) log0.push_back(v);
          else if (i == 1) log1.push_back(v);
          else log2.push_back(v);
        end
        if (!rst_n) begin
          cnt_m[i] = 0; part_m[i] = 0; rv_m[i] = 0; rs_m[i] = 0; ro_m[i] = 0;
        end else begin
          acc_ok = iv[i] && (exp_rdy == 1);
          take   = rv_m[i] && sr[i];
          if (acc_ok) begin
            part_m[i] += longint'(prod[i]);
            cnt_m[i]++;
          end
          if (acc_ok && cnt_m[i] == t) begin
`ifdef SOP_SAT_EN
            rs_m[i] = int'((part_m[i] > maxv) ? maxv : part_m[i]);
            ro_m[i] = (part_m[i] > maxv);
`else
            rs_m[i] = int'(part_m[i] % (maxv + 1));
            ro_m[i] = 1'b0;
`endif
            rv_m[i]   = 1'b1;
            cnt_m[i]  = 0;
            part_m[i] = 0;
          end else if (take) begin
            rv_m[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_log(int i, int exp_sum, int exp_ovf, string name);
    int v;
    bit have;
    have = 1'b0;
    v    = 0;
    if (i == 0 && log0.size() > 0) begin v = log0.pop_front(); have = 1'b1; end
    if (i == 1 && log1.size() > 0) begin v = log1.pop_front(); have = 1'b1; end
    if (i == 2 && log2.size() > 0) begin v = log2.pop_front(); have = 1'b1; end
    if (!have) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no result taken, expected sum %0d", name, exp_sum);
    end else begin
      chk(name, v & 32'hffff, exp_sum);
      chk({name, "_ovf"}, v >> 16, exp_ovf);
    end
  endtask

  task automatic expect_empty(int i, string name);
    int n;
    n = (i == 0) ? log0.size() : (i == 1) ? log1.size() : log2.size();
    chk(name, n, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    iv    = '0;
    sr    = '0;
    for (int i = 0; i < 3; i++) prod[i] = '0;
    tick();
    started = 1'b1;
    tick();
    chk("rst_in_ready", int'(ir[0]), 1);
    chk("rst_sum_valid", int'(sv[0]), 0);
    chk("rst_sum", int'(sm[0]), 0);
    chk("rst_ovf", int'(ov[2]), 0);

    // 225 x4 on default and narrow instances; 10,20,30 on the TERMS=1 instance.
    rst_n = 1'b1;
    sr    = 3'b111;
    for (int c = 0; c < 4; c++) begin
      iv[0] = 1'b1; prod[0] = 8'd225;
      iv[2] = 1'b1; prod[2] = 8'd225;
      iv[1] = (c < 3); prod[1] = 8'(10 * (c + 1));
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      iv[0] = 1'b0; iv[1] = 1'b0;
      iv[2] = 1'b1; prod[2] = 8'd1;
      tick();
    end
    iv = '0;
    repeat (3) tick();
    expect_log(0, 900, 0, "t1_sum900");
    expect_empty(0, "t1_single_pulse");
    expect_log(2, T5_SUM, T5_OVF, "t5_group1");
    expect_log(2, 4, 0, "t5_group2");
    expect_empty(2, "t5_count");
    expect_log(1, 10, 0, "t6_sum10");
    expect_log(1, 20, 0, "t6_sum20");
    expect_log(1, 30, 0, "t6_sum30");
    expect_empty(1, "t6_count");

    // Partial group discarded by reset.
    iv[0] = 1'b1; prod[0] = 8'd5;
    repeat (2) tick();
    iv[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("t2_ready_in_rst", int'(ir[0]), 1);
    chk("t2_valid_in_rst", int'(sv[0]), 0);
    rst_n = 1'b1;
    iv[0] = 1'b1; prod[0] = 8'd1;
    repeat (4) tick();
    iv[0] = 1'b0;
    repeat (3) tick();
    expect_log(0, 4, 0, "t2_sum4");
    expect_empty(0, "t2_count");

    // Stall on the completing term of the second group.
    sr[0] = 1'b0;
    iv[0] = 1'b1; prod[0] = 8'd1;
    repeat (7) tick();
    chk("t3_stall", int'(ir[0]), 0);
    repeat (2) tick();
    chk("t3_still_stalled", int'(ir[0]), 0);
    chk("t3_held_valid", int'(sv[0]), 1);
    chk("t3_held_sum", int'(sm[0]), 4);
    sr[0] = 1'b1;
    #1;
    chk("t3_release", int'(ir[0]), 1);
    tick();
    iv[0] = 1'b0;
    chk("t3_valid_kept", int'(sv[0]), 1);
    repeat (2) tick();
    expect_log(0, 4, 0, "t3_first");
    expect_log(0, 4, 0, "t3_second");
    expect_empty(0, "t3_count");

    // Gapped input: 3,9,5,7 with garbage on idle cycles.
    for (int c = 0; c < 8; c++) begin
      iv[0] = (c % 2 == 0);
      case (c)
        0: prod[0] = 8'd3;
        2: prod[0] = 8'd9;
        4: prod[0] = 8'd5;
        6: prod[0] = 8'd7;
        default: prod[0] = 8'($urandom);
      endcase
      tick();
    end
    iv[0] = 1'b0;
    repeat (3) tick();
    expect_log(0, 24, 0, "t4_sum24");
    expect_empty(0, "t4_count");

    // Random traffic, backpressure and occasional reset on all instances.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 3; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        sr[i]   = ($urandom_range(0, 2) != 0);
        prod[i] = 8'($urandom);
      end
      tick();
    end
    rst_n = 1'b1;
    iv    = '0;
    sr    = 3'b111;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
